// File: rtl/alif_param_serializer.sv
// Host-side transmitter for the ALIF neuron serial configuration loader: one parallel
// parameter set becomes a 35-bit MSB-first load_mode/serial_data frame. Macro CONFIG_VERIFY_EN adds a loader ready check.
module alif_param_serializer #(
  parameter int BIT_CYCLES    = 1,
  parameter int READY_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       start,
  input  logic [2:0] weight_a,
  input  logic [7:0] leak_rate_1,
  input  logic [7:0] leak_rate_2,
  input  logic [7:0] threshold_min,
  input  logic [3:0] leak_cycles_1,
  input  logic [3:0] leak_cycles_2,
  input  logic       params_ready,
  output logic       load_mode,
  output logic       serial_data,
  output logic       busy,
  output logic       done,
  output logic       cfg_error
);

  localparam int         FRAME_BITS = 35;
  localparam logic [5:0] LAST_BIT   = 6'(FRAME_BITS - 1);
  localparam logic [3:0] HOLD_LAST  = 4'(BIT_CYCLES - 1);

`ifdef CONFIG_VERIFY_EN
  localparam int              WAIT_W    = $clog2(READY_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READY_TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2, WAIT_RDY = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
`endif

  state_t                  state_r, state_s;
  logic [FRAME_BITS-1:0]   shift_r, shift_s;
  logic [5:0]              bit_cnt_r, bit_cnt_s;
  logic [3:0]              hold_cnt_r, hold_cnt_s;
  logic                    load_mode_r, serial_data_r, busy_r, done_r;

`ifdef CONFIG_VERIFY_EN
  logic [WAIT_W-1:0]       wait_cnt_r, wait_cnt_s;
  logic                    cfg_error_r, err_s;
`else
  logic                    unused_verify_s;
`endif

  // Next-state, shift register and counter computation; applied only on enabled edges.
  always_comb begin
    state_s    = state_r;
    shift_s    = shift_r;
    bit_cnt_s  = bit_cnt_r;
    hold_cnt_s = hold_cnt_r;
`ifdef CONFIG_VERIFY_EN
    wait_cnt_s = wait_cnt_r;
    err_s      = cfg_error_r;
`endif
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s    = SHIFT;
          shift_s    = {weight_a, leak_rate_1, leak_rate_2, threshold_min,
                        leak_cycles_1, leak_cycles_2};
          bit_cnt_s  = 6'd0;
          hold_cnt_s = 4'd0;
`ifdef CONFIG_VERIFY_EN
          err_s      = 1'b0;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (hold_cnt_r == HOLD_LAST) begin
          hold_cnt_s = 4'd0;
          if (bit_cnt_r == LAST_BIT) begin
            bit_cnt_s = 6'd0;
`ifdef CONFIG_VERIFY_EN
            wait_cnt_s = {WAIT_W{1'b0}};
            state_s    = WAIT_RDY;
`else
            state_s    = DONE;
`endif
          end else begin
            // the next bit to present always sits at the MSB
            bit_cnt_s = bit_cnt_r + 6'd1;
            shift_s   = {shift_r[FRAME_BITS-2:0], 1'b0};
          end
        end else begin
          hold_cnt_s = hold_cnt_r + 4'd1;
        end
      end
`ifdef CONFIG_VERIFY_EN
      WAIT_RDY: begin
        if (params_ready) begin
          state_s = DONE;
          err_s   = 1'b0;
        end else if (wait_cnt_r == WAIT_LAST) begin
          state_s = DONE;
          err_s   = 1'b1;
        end else begin
          wait_cnt_s = wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
        end
      end
`endif
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs; outputs are derived from the next state so the
  // first bit appears right after the edge that accepts start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      shift_r       <= {FRAME_BITS{1'b0}};
      bit_cnt_r     <= 6'd0;
      hold_cnt_r    <= 4'd0;
      load_mode_r   <= 1'b0;
      serial_data_r <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else if (enable) begin
      state_r       <= state_s;
      shift_r       <= shift_s;
      bit_cnt_r     <= bit_cnt_s;
      hold_cnt_r    <= hold_cnt_s;
      load_mode_r   <= (state_s == SHIFT);
      serial_data_r <= (state_s == SHIFT) ? shift_s[FRAME_BITS-1] : 1'b0;
      busy_r        <= (state_s != IDLE);
      done_r        <= (state_s == DONE);
    end
  end

`ifdef CONFIG_VERIFY_EN
  // Ready-wait counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_r  <= {WAIT_W{1'b0}};
      cfg_error_r <= 1'b0;
    end else if (enable) begin
      wait_cnt_r  <= wait_cnt_s;
      cfg_error_r <= err_s;
    end
  end

  assign cfg_error = cfg_error_r;
`else
  assign unused_verify_s = params_ready & (READY_TIMEOUT > 32'sd0);
  assign cfg_error       = 1'b0;
`endif

  assign load_mode   = load_mode_r;
  assign serial_data = serial_data_r;
  assign busy        = busy_r;
  assign done        = done_r;

endmodule

// File: tb/tb_alif_param_serializer.sv
// Bench for alif_param_serializer: two instances (BIT_CYCLES 1 and 3) share stimulus; each
// recorded output trace is compared with a trace built from the frame rules.
module tb_alif_param_serializer;

  localparam int READY_TO = 64;
  localparam int NC_BASE  = 180;

  logic       clk = 1'b0;
  logic       reset, enable, start, params_ready;
  logic [2:0] weight_a;
  logic [7:0] lr1, lr2, thm;
  logic [3:0] lc1, lc2;
  logic       lm1, sd1, bz1, dn1, er1;
  logic       lm3, sd3, bz3, dn3, er3;

  alif_param_serializer #(.BIT_CYCLES(1), .READY_TIMEOUT(READY_TO)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .weight_a(weight_a),
    .leak_rate_1(lr1), .leak_rate_2(lr2), .threshold_min(thm), .leak_cycles_1(lc1),
    .leak_cycles_2(lc2), .params_ready(params_ready), .load_mode(lm1), .serial_data(sd1),
    .busy(bz1), .done(dn1), .cfg_error(er1));

  alif_param_serializer #(.BIT_CYCLES(3), .READY_TIMEOUT(READY_TO)) dut3 (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .weight_a(weight_a),
    .leak_rate_1(lr1), .leak_rate_2(lr2), .threshold_min(thm), .leak_cycles_1(lc1),
    .leak_cycles_2(lc2), .params_ready(params_ready), .load_mode(lm3), .serial_data(sd3),
    .busy(bz3), .done(dn3), .cfg_error(er3));

  always #5 clk = ~clk;

  logic       rec = 1'b0;
  logic [4:0] tr1[$];
  logic [4:0] tr3[$];
  logic [4:0] ex[$];
  int         n_total = 0;
  int         n_pass  = 0;

  // current frame description: parameters, freeze start/length, ready time, glitch start
  logic [2:0] f_w;
  logic [7:0] f_l1, f_l2, f_th;
  logic [3:0] f_c1, f_c2;
  int         f_fa, f_fl, f_ra, f_ga;

  // Per-cycle output trace of both instances, sampled mid-cycle.
  always @(negedge clk) begin
    if (rec) begin
      tr1.push_back({lm1, sd1, bz1, dn1, er1});
      tr3.push_back({lm3, sd3, bz3, dn3, er3});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv,
                       output bit ok);
    n_total++;
    ok = (obs === expv);
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Expected trace: each frame bit repeated b cycles, optional ready wait, one done cycle,
  // then idle; a freeze repeats the held sample.
  task automatic build_exp(input int b, input int nc);
    bit         fb[$];
    logic [7:0] vals[6];
    int         widths[6];
    int         last, d;
    logic       e;
    logic [4:0] held;
    vals   = '{{5'd0, f_w}, f_l1, f_l2, f_th, {4'd0, f_c1}, {4'd0, f_c2}};
    widths = '{3, 8, 8, 8, 4, 4};
    for (int f = 0; f < 6; f++)
      for (int i = widths[f] - 1; i >= 0; i--) fb.push_back(vals[f][i]);
    ex.delete();
    foreach (fb[i]) repeat (b) ex.push_back({1'b1, fb[i], 1'b1, 1'b0, 1'b0});
    last = 35 * b;
    d    = last;
    e    = 1'b0;
`ifdef CONFIG_VERIFY_EN
    if (f_ra + 1 <= last + READY_TO) d = (f_ra + 1 > last + 1) ? f_ra + 1 : last + 1;
    else begin
      d = last + READY_TO;
      e = 1'b1;
    end
`endif
    while (ex.size() < d) ex.push_back(5'b00100);
    ex.push_back({4'b0011, e});
    while (ex.size() < nc - f_fl) ex.push_back({4'b0000, e});
    if (f_fl > 0) begin
      held = ex[f_fa];
      for (int i = 0; i < f_fl; i++) ex.insert(f_fa + 1, held);
    end
  endtask

  task automatic cmp_trace(input string tag, input int b, input int nc);
    logic [4:0] got[$];
    bit         ok;
    int         n;
    build_exp(b, nc);
    if (b == 1) got = tr1;
    else got = tr3;
    check({tag, "/len"}, got.size(), ex.size(), ok);
    n = (got.size() < ex.size()) ? got.size() : ex.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s/cyc%0d", tag, i), {27'd0, got[i]}, {27'd0, ex[i]}, ok);
      if (!ok) break;
    end
  endtask

  task automatic randomize_inputs();
    weight_a = 3'($urandom);
    lr1 = 8'($urandom);
    lr2 = 8'($urandom);
    thm = 8'($urandom);
    lc1 = 4'($urandom);
    lc2 = 4'($urandom);
  endtask

  task automatic run_frame(input string tag);
    int nc;
    nc = NC_BASE + f_fl;
    tr1.delete();
    tr3.delete();
    @(posedge clk); #1;
    weight_a = f_w; lr1 = f_l1; lr2 = f_l2; thm = f_th; lc1 = f_c1; lc2 = f_c2;
    start = 1'b1; enable = 1'b1; params_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    rec   = 1'b1;
    for (int k = 0; k < nc; k++) begin
      enable       = !(k >= f_fa && k < f_fa + f_fl);
      params_ready = (k >= f_ra);
      start        = (k == f_ga);
      randomize_inputs();
      @(posedge clk); #1;
    end
    rec = 1'b0; start = 1'b0; enable = 1'b1; params_ready = 1'b0;
    cmp_trace({tag, "/bc1"}, 1, nc);
    cmp_trace({tag, "/bc3"}, 3, nc);
  endtask

  task automatic check_zero(input string tag);
    bit ok;
    check(tag, {22'd0, lm1, sd1, bz1, dn1, er1, lm3, sd3, bz3, dn3, er3}, 32'd0, ok);
  endtask

  task automatic set_frame(input logic [2:0] w, input logic [7:0] l1, input logic [7:0] l2,
                           input logic [7:0] th, input logic [3:0] c1, input logic [3:0] c2,
                           input int fa, input int fl, input int ra, input int ga);
    f_w = w; f_l1 = l1; f_l2 = l2; f_th = th; f_c1 = c1; f_c2 = c2;
    f_fa = fa; f_fl = fl; f_ra = ra; f_ga = ga;
  endtask

  initial begin
    bit ok;
    reset = 1'b1; enable = 1'b1; start = 1'b0; params_ready = 1'b0;
    randomize_inputs();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk); check_zero("reset_state");

    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 reset = 1'b0; start = 1'b0;
    @(negedge clk); check_zero("reset_beats_start");

    @(posedge clk); #1 enable = 1'b0; start = 1'b1;
    @(posedge clk); #1 enable = 1'b1; start = 1'b0;
    @(negedge clk); check_zero("start_while_disabled");
    @(negedge clk); check_zero("start_while_disabled_2");

    set_frame(3'b101, 8'hA5, 8'h3C, 8'h80, 4'h9, 4'h6, -1, 0, 0, -1);
    run_frame("plan_frame");
    set_frame(3'b101, 8'hA5, 8'h3C, 8'h80, 4'h9, 4'h6, 13, 10, 0, -1);
    run_frame("freeze10");
    set_frame(3'b101, 8'hA5, 8'h3C, 8'h80, 4'h9, 4'h6, -1, 0, 0, 19);
    run_frame("start_while_busy");

    @(posedge clk); #1;
    randomize_inputs();
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (16) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("midframe_load_mode", {30'd0, lm1, lm3}, 32'd3, ok);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk); check_zero("reset_midframe");

    set_frame(3'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
              4'($urandom), -1, 0, 0, -1);
    run_frame("after_reset");
    set_frame(3'b011, 8'h5A, 8'hC3, 8'h01, 4'hF, 4'h0, -1, 0, 39, -1);
    run_frame("ready_late");
    set_frame(3'b110, 8'hFF, 8'h00, 8'h7E, 4'h1, 4'h8, -1, 0, 1000000, -1);
    run_frame("ready_timeout");
    set_frame(3'b001, 8'h12, 8'h34, 8'h56, 4'h7, 4'h8, -1, 0, 0, -1);
    run_frame("error_cleared");

    for (int r = 0; r < 4; r++) begin
      set_frame(3'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
                4'($urandom), int'($urandom_range(0, 30)), int'($urandom_range(1, 8)), 0,
                int'($urandom_range(0, 33)));
      run_frame($sformatf("random%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
